// File: rtl/kbd_ascii_pkg.sv
// Shared definitions for the scan-code-set-2 to ASCII translator:
// prefix FSM states, scancode constants and the translation tables.
package kbd_ascii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic sc_is_ignored(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic sc_is_letter(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Non-extended make translation; 0x00 means "no character".
  // Each entry is {unshifted, shifted}.
  function automatic logic [7:0] sc2ascii(input logic [7:0] code, input logic shift);
    logic [15:0] pair;
    pair = 16'h0000;
    case (code)
      8'h1C: pair = {"a", "A"};
      8'h32: pair = {"b", "B"};
      8'h21: pair = {"c", "C"};
      8'h23: pair = {"d", "D"};
      8'h24: pair = {"e", "E"};
      8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};
      8'h33: pair = {"h", "H"};
      8'h43: pair = {"i", "I"};
      8'h3B: pair = {"j", "J"};
      8'h42: pair = {"k", "K"};
      8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};
      8'h31: pair = {"n", "N"};
      8'h44: pair = {"o", "O"};
      8'h4D: pair = {"p", "P"};
      8'h15: pair = {"q", "Q"};
      8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};
      8'h2C: pair = {"t", "T"};
      8'h3C: pair = {"u", "U"};
      8'h2A: pair = {"v", "V"};
      8'h1D: pair = {"w", "W"};
      8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};
      8'h1A: pair = {"z", "Z"};
      8'h16: pair = {"1", "!"};
      8'h1E: pair = {"2", "@"};
      8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};
      8'h2E: pair = {"5", "%"};
      8'h36: pair = {"6", "^"};
      8'h3D: pair = {"7", "&"};
      8'h3E: pair = {"8", "*"};
      8'h46: pair = {"9", "("};
      8'h45: pair = {"0", ")"};
      8'h0E: pair = {8'h60, 8'h7E};
      8'h4E: pair = {"-", "_"};
      8'h55: pair = {"=", "+"};
      8'h54: pair = {"[", "{"};
      8'h5B: pair = {"]", "}"};
      8'h5D: pair = {8'h5C, 8'h7C};
      8'h4C: pair = {";", ":"};
      8'h52: pair = {8'h27, 8'h22};
      8'h41: pair = {",", "<"};
      8'h49: pair = {".", ">"};
      8'h4A: pair = {"/", "?"};
      SC_SPACE: pair = 16'h2020;
      SC_ENTER: pair = 16'h0D0D;
      SC_BKSP:  pair = 16'h0808;
      SC_TAB:   pair = 16'h0909;
      SC_ESC:   pair = 16'h1B1B;
      default:  pair = 16'h0000;
    endcase
    return shift ? pair[7:0] : pair[15:8];
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// Small first-word-fall-through stream FIFO with registered storage.
// Output data reads as zero while empty so it is defined out of reset.
module axis_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_fifo DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        full, empty, wr_en, rd_en;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign wr_en     = in_valid & ~full;
  assign rd_en     = out_ready & ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/kbd_ascii_axis.sv
// PS/2 set-2 scancode stream to ASCII/extended-key stream translator.
// Tracks prefix/break state and modifiers; characters queue in axis_fifo.
module kbd_ascii_axis
  import kbd_ascii_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  input  logic [7:0] s_axis_tdata_i,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic [7:0] m_axis_tdata_o,
  output logic [2:0] mods_o
);

  kbd_state_e state_reg, state_next;
  logic       en_reg;
  logic       lshift_reg, rshift_reg, lctrl_reg, rctrl_reg;
  logic       caps_reg, caps_down_reg;

  logic       fifo_in_ready, accept;
  logic       is_key, is_make, is_ext, is_letter;
  logic       hit_lshift, hit_rshift, hit_lctrl, hit_rctrl, hit_caps, is_mod;
  logic       shift, ctrl;
  logic [7:0] code, char_code;
  logic       char_valid;

  assign code            = s_axis_tdata_i;
  assign s_axis_tready_o = en_reg & fifo_in_ready;
  assign accept          = s_axis_tvalid_i & s_axis_tready_o;

  assign shift  = lshift_reg | rshift_reg;
  assign ctrl   = lctrl_reg | rctrl_reg;
  assign mods_o = {caps_reg, ctrl, shift};

  assign is_make = (state_reg == ST_IDLE) || (state_reg == ST_EXT);
  assign is_ext  = (state_reg == ST_EXT)  || (state_reg == ST_EXT_BRK);

  always_comb begin
    state_next = state_reg;
    is_key     = 1'b0;
    if (code == SC_EXT) begin
      state_next = ST_EXT;
    end else if (code == SC_BRK) begin
      case (state_reg)
        ST_IDLE: state_next = ST_BRK;
        ST_EXT:  state_next = ST_EXT_BRK;
        default: state_next = state_reg;
      endcase
    end else if (sc_is_ignored(code)) begin
      state_next = ST_IDLE;
    end else begin
      is_key     = 1'b1;
      state_next = ST_IDLE;
    end
  end

  assign hit_lshift = !is_ext && (code == SC_LSHIFT);
  assign hit_rshift = !is_ext && (code == SC_RSHIFT);
  assign hit_lctrl  = !is_ext && (code == SC_CTRL);
  assign hit_rctrl  =  is_ext && (code == SC_CTRL);
  assign hit_caps   = !is_ext && (code == SC_CAPS);
  assign is_mod     = hit_lshift | hit_rshift | hit_lctrl | hit_rctrl | hit_caps;
  assign is_letter  = !is_ext && sc_is_letter(code);

  // Ctrl folds a letter onto its control code independent of case.
  always_comb begin
    char_code = 8'h00;
    if (is_ext) begin
      case (code)
        SC_UP:    char_code = KEY_UP;
        SC_DOWN:  char_code = KEY_DOWN;
        SC_LEFT:  char_code = KEY_LEFT;
        SC_RIGHT: char_code = KEY_RIGHT;
        default:  char_code = 8'h00;
      endcase
    end else if (is_letter && ctrl) begin
      char_code = sc2ascii(code, 1'b0) & 8'h1F;
    end else if (is_letter) begin
      char_code = sc2ascii(code, shift ^ caps_reg);
    end else begin
      char_code = sc2ascii(code, shift);
    end
  end

  assign char_valid = is_key && is_make && !is_mod && (char_code != 8'h00);

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      en_reg        <= 1'b0;
      state_reg     <= ST_IDLE;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      lctrl_reg     <= 1'b0;
      rctrl_reg     <= 1'b0;
      caps_reg      <= 1'b0;
      caps_down_reg <= 1'b0;
    end else begin
      en_reg <= 1'b1;
      if (accept) begin
        state_reg <= state_next;
        if (is_key) begin
          if (hit_lshift) lshift_reg <= is_make;
          if (hit_rshift) rshift_reg <= is_make;
          if (hit_lctrl)  lctrl_reg  <= is_make;
          if (hit_rctrl)  rctrl_reg  <= is_make;
          // caps_down suppresses re-toggling on typematic repeat.
          if (hit_caps) begin
            if (is_make && !caps_down_reg) caps_reg <= ~caps_reg;
            caps_down_reg <= is_make;
          end
        end
      end
    end
  end

  axis_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (axis_aclk_i),
    .rst_ni    (axis_aresetn_i),
    .in_valid  (accept & char_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (char_code),
    .out_valid (m_axis_tvalid_o),
    .out_ready (m_axis_tready_i),
    .out_data  (m_axis_tdata_o)
  );

endmodule

// File: tb/tb_kbd_ascii_axis.sv
// Directed scoreboard bench for kbd_ascii_axis: stimulus pushes expected
// characters, an independent monitor pops and compares each output byte.
module tb_kbd_ascii_axis;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tvalid, s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready;
  logic [7:0] m_tdata;
  logic [2:0] mods;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  kbd_ascii_axis #(.FIFO_DEPTH(4)) dut (
    .axis_aclk_i     (clk),
    .axis_aresetn_i  (rst_n),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .s_axis_tdata_i  (s_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .m_axis_tdata_o  (m_tdata),
    .mods_o          (mods)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%02h required=none", m_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("out %02h expected %02h", m_tdata, mon_exp);
        check("out_byte", m_tdata, mon_exp);
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  // Called away from the edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = c;
    @(negedge clk);
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=tready_low required=accept code=%02h", c);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    $display("in  %02h mods=%03b", c, mods);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_tvalid"}, m_tvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 8'h00);
    check("rst_mods", mods, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("release_tready_low", s_tready, 1'b0);
    @(posedge clk);
    #1;
    check("release_tready_high", s_tready, 1'b1);

    // Plain letter
    expect_byte(8'h61);
    send(8'h1C);
    check("t1_mods", mods, 3'b000);
    send(8'hF0); send(8'h1C);
    drain("t1");

    // Shifted letter
    send(8'h12);
    check("t2_mods_shift", mods, 3'b001);
    expect_byte(8'h41);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    check("t2_mods_held", mods, 3'b001);
    send(8'hF0); send(8'h12);
    check("t2_mods_rel", mods, 3'b000);
    drain("t2");

    // Caps lock toggling and typematic suppression
    send(8'h58);
    check("t3_caps_on", mods, 3'b100);
    send(8'hF0); send(8'h58);
    check("t3_caps_brk", mods, 3'b100);
    expect_byte(8'h41);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h58);
    check("t3_caps_off", mods, 3'b000);
    send(8'hF0); send(8'h58);
    send(8'h58); send(8'h58);
    check("t3_typematic", mods, 3'b100);
    send(8'hF0); send(8'h58);
    check("t3_typematic_brk", mods, 3'b100);
    send(8'h12);
    expect_byte(8'h61);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps_clear", mods, 3'b000);
    drain("t3");

    // Ctrl, extended keys, ignored codes, specials
    send(8'h14);
    check("t4_lctrl", mods, 3'b010);
    expect_byte(8'h03);
    send(8'h21);
    send(8'hF0); send(8'h21);
    send(8'hF0); send(8'h14);
    check("t4_lctrl_rel", mods, 3'b000);
    send(8'hE0); send(8'h14);
    check("t4_rctrl", mods, 3'b010);
    expect_byte(8'h1A);
    send(8'h1A);
    send(8'hF0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("t4_rctrl_rel", mods, 3'b000);
    expect_byte(8'h80);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA);
    send(8'h12);
    expect_byte(8'h21);
    send(8'h16);
    send(8'hF0); send(8'h16);
    send(8'hF0); send(8'h12);
    expect_byte(8'h20);
    send(8'h29);
    expect_byte(8'h0D);
    send(8'h5A);
    expect_byte(8'h81);
    send(8'hE0); send(8'h72);
    expect_byte(8'h61);
    expect_byte(8'h61);
    send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    drain("t4");

    // Backpressure: fill the FIFO, then drain it
    m_tready = 1'b0;
    expect_byte(8'h31); send(8'h16);
    expect_byte(8'h32); send(8'h1E);
    expect_byte(8'h33); send(8'h26);
    expect_byte(8'h34); send(8'h25);
    check("t5_full_tready", s_tready, 1'b0);
    check("t5_full_tvalid", m_tvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_tready", s_tready, 1'b0);
      check("t5_hold_tdata", m_tdata, 8'h31);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    expect_byte(8'h35);
    send(8'h2E);
    drain("t5");

    // Reset in the middle of a prefix sequence
    send(8'h12);
    send(8'hE0); send(8'hF0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mods", mods, 3'b000);
    check("t6_rst_tready", s_tready, 1'b0);
    check("t6_rst_tvalid", m_tvalid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_byte(8'h61);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_ascii_axis.md
# kbd_ascii_axis

PS/2 scan-code-set-2 to ASCII translator between the keyboard receiver (`kbd_axis`) and the CPU-facing stream interface (`if_axis`). It consumes raw 8-bit scancodes on an AXI-Stream slave, tracks prefix, break, shift, ctrl and caps-lock state, and emits one ASCII or extended key byte per key press on an AXI-Stream master through a small output FIFO. It replaces the direct scancode path so software reads characters rather than scancodes.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of 2 and at least 2.
- `axis_aclk_i` in 1: clock, the SoC 50 MHz `clock`.
- `axis_aresetn_i` in 1: reset, asynchronous, active-low.
- `s_axis_tvalid_i` in 1: scancode valid, driven by `kbd_axis`.
- `s_axis_tready_o` out 1: scancode accepted this cycle when high together with valid.
- `s_axis_tdata_i` in 8: raw scancode.
- `m_axis_tvalid_o` out 1: character available, consumed by `if_axis`.
- `m_axis_tready_i` in 1: consumer accepts the character.
- `m_axis_tdata_o` out 8: ASCII or extended key code.
- `mods_o` out 3: `{caps_lock, ctrl, shift}` live modifier state.

## Operation
- Accept handshake is `s_axis_tvalid_i & s_axis_tready_o`. `s_axis_tready_o` is a registered enable flop ANDed with FIFO not-full. The flop is 0 in reset and 1 from the first clock after release.
- Prefix FSM has states IDLE, EXT, BRK and EXT_BRK.
  - 0xE0 in any state goes to EXT.
  - 0xF0 goes IDLE→BRK and EXT→EXT_BRK; in BRK or EXT_BRK it holds the state.
  - Any other accepted code is a key event and returns the FSM to IDLE.
  - Key events are make in IDLE/EXT, break in BRK/EXT_BRK, and extended in EXT/EXT_BRK.
- Codes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE and 0xFF are ignored in any state: no event, FSM returns to IDLE.
- Modifiers are updated on both make and break.
  - `lshift` is 0x12, `rshift` is 0x59, `lctrl` is 0x14, `rctrl` is E0 14.
  - `shift = lshift|rshift`; `ctrl = lctrl|rctrl`.
  - Caps lock is 0x58. It toggles on make only when `caps_down` is 0. `caps_down` is set on make and cleared on break, so typematic repeat does not re-toggle.
- Break events never emit a character. Modifier make events never emit a character.
- Make-event translation:
  - Letters 0x15..0x4D (set-2 letter codes) map to lowercase 'a'..'z'. Uppercase applies when `shift ^ caps`.
  - Digit and punctuation keys use the shift-only table ('1'/'!', ';'/':', etc.).
  - Space 0x29 → 0x20; Enter 0x5A → 0x0D; Backspace 0x66 → 0x08; Tab 0x0D → 0x09; Esc 0x76 → 0x1B.
  - Extended arrows: E0 75 → 0x80 (up), E0 72 → 0x81 (down), E0 6B → 0x82 (left), E0 74 → 0x83 (right).
  - Other extended keys and unmapped codes emit nothing.
  - With `ctrl` set, a letter emits `ascii & 0x1F` regardless of shift or caps.
- Typematic repeat (repeated make without break) emits on every make.
- FIFO:
  - Written at the accepting edge when a character is produced; read on `m_axis_tvalid_o & m_axis_tready_i`.
  - Simultaneous read and write when non-full keeps the count unchanged.
  - Never overflows, because `s_axis_tready_o` is low when full.
- `m_axis_tdata_o` is held stable while valid is high and ready is low.

## Timing
- Reset values: `s_axis_tready_o`=0, `m_axis_tvalid_o`=0, `m_axis_tdata_o`=0x00, `mods_o`=0. FSM is IDLE, FIFO is empty, and all modifier and `caps_down` flags are 0.
- Latency: a scancode accepted at edge N into an empty FIFO gives `m_axis_tvalid_o`=1 with data after edge N (first-word fall-through, registered storage).
- `mods_o` reflects the event from the edge at which its code was accepted.
- Full FIFO: `s_axis_tready_o` drops in the cycle after the write that fills it. It returns the cycle after the first read.
- Reset asserted mid-sequence (e.g. after E0 F0) clears everything asynchronously. The next code is interpreted from IDLE.

## Structure
- Package `kbd_ascii_pkg` holds:
  - the FSM state enum;
  - scancode constants (prefixes, modifiers, special keys);
  - extended key codes 0x80–0x83;
  - functions `sc2ascii(code, shift)` and `sc_is_letter(code)`.
- Sub-module `axis_fifo` (parameter `DEPTH`, width 8) holds the output FIFO. It is reused elsewhere for stream buffering.

## Test plan
- Reset release, then 1C, F0 1C → one byte 0x61 ('a'); `mods_o`=000; FIFO empty afterwards.
- 12, 1C, F0 1C, F0 12 → 0x41 ('A'). `mods_o`=001 between 12 and F0 12, and 000 after.
- 58, F0 58, 58, F0 58 with 1C in between → 0x41; caps bit 1 then 0. The sequence 58, 58, F0 58 (typematic) toggles once only.
- 14, 21 → 0x03; E0 75, E0 F0 75 → single 0x80; AA, FA → no output.
- `m_axis_tready_i`=0 while sending five make codes 16, 1E, 26, 25, 2E → `s_axis_tready_o` low after the fourth. Raising ready drains '1','2','3','4' in order, then '5' is accepted.
- Send E0 F0, assert reset, release, send 1C → output 0x61.
